// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the parametrised N-way data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    FILL
  } state_e;

  function automatic int unsigned offset_w(int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int unsigned index_w(int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(int unsigned addr_w, int unsigned line_bytes,
                                        int unsigned sets);
    return addr_w - offset_w(line_bytes) - index_w(sets);
  endfunction

  function automatic int unsigned word_sel_w(int unsigned line_bytes, int unsigned data_w);
    return $clog2((line_bytes * 8) / data_w);
  endfunction

  // Builds {tag, index, zero offset}; callers size-cast the result to ADDR_W.
  function automatic logic [63:0] line_addr(logic [63:0] tag, logic [63:0] index,
                                            int unsigned index_bits, int unsigned offset_bits);
    return ((tag << index_bits) | index) << offset_bits;
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: tag/valid/dirty per set plus line data, read combinationally by index.
module dcache_way_array
  import dcache_pkg::*;
#(
  parameter int unsigned SETS    = 16,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TAG_W   = 23,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WS_W    = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [LINE_W-1:0]  line_o,
  input  logic               fill_i,
  input  logic [INDEX_W-1:0] fill_idx_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [LINE_W-1:0]  fill_line_i,
  input  logic               wr_i,
  input  logic [WS_W-1:0]    wr_sel_i,
  input  logic [DATA_W-1:0]  wr_data_i
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  assign valid_o = valid_q[rd_idx_i];
  assign dirty_o = dirty_q[rd_idx_i];
  assign tag_o   = tag_q[rd_idx_i];
  assign line_o  = line_q[rd_idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) tag_q[s] <= '0;
    end else begin
      if (fill_i) begin
        valid_q[fill_idx_i] <= 1'b1;
        dirty_q[fill_idx_i] <= 1'b0;
        tag_q[fill_idx_i]   <= fill_tag_i;
      end
      if (wr_i) dirty_q[rd_idx_i] <= 1'b1;
    end
  end

  // Data is never reset; valid gates every use of it.
  always_ff @(posedge clk_i) begin
    if (fill_i) line_q[fill_idx_i] <= fill_line_i;
    if (wr_i) line_q[rd_idx_i][wr_sel_i*DATA_W +: DATA_W] <= wr_data_i;
  end

endmodule

// File: rtl/dcache_nway_controller.sv
// Write-back, write-allocate N-way data cache with true-LRU replacement for the MEM stage.
module dcache_nway_controller
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned SETS       = 16,
  parameter int unsigned WAYS       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpu_MemRead_i,
  input  logic                    cpu_MemWrite_i,
  input  logic [ADDR_W-1:0]       cpu_addr_i,
  input  logic [DATA_W-1:0]       cpu_data_i,
  output logic [DATA_W-1:0]       cpu_data_o,
  output logic                    cpu_stall_o,
  input  logic [LINE_BYTES*8-1:0] mem_data_i,
  input  logic                    mem_ack_i,
  output logic [LINE_BYTES*8-1:0] mem_data_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic                    mem_enable_o,
  output logic                    mem_write_o
);

  localparam int unsigned OFFSET_W   = offset_w(LINE_BYTES);
  localparam int unsigned INDEX_W    = index_w(SETS);
  localparam int unsigned TAG_W      = tag_w(ADDR_W, LINE_BYTES, SETS);
  localparam int unsigned WORD_SEL_W = word_sel_w(LINE_BYTES, DATA_W);
  localparam int unsigned WS_W       = (WORD_SEL_W > 0) ? WORD_SEL_W : 1;
  localparam int unsigned BYTE_W     = $clog2(DATA_W / 8);
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [WS_W-1:0]    word_sel;
  logic               req;
  logic               unused_addr_bits;

  assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx          = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign req              = cpu_MemRead_i | cpu_MemWrite_i;
  assign unused_addr_bits = ^cpu_addr_i[BYTE_W-1:0];

  if (WORD_SEL_W > 0) begin : g_wsel
    assign word_sel = cpu_addr_i[BYTE_W +: WORD_SEL_W];
  end else begin : g_wsel1
    assign word_sel = '0;
  end

  state_e             state_q;
  logic               mem_enable_q, mem_write_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [LINE_W-1:0]  mem_data_q;
  logic [WAY_W-1:0]   victim_q;
  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] req_idx_q;

  logic [WAYS-1:0]    way_valid, way_dirty, way_fill, way_wr;
  logic [TAG_W-1:0]   way_tag  [WAYS];
  logic [LINE_W-1:0]  way_line [WAYS];
  logic [WAY_W-1:0]   age_row  [WAYS];

  logic               hit, found;
  logic [WAY_W-1:0]   hit_way, victim;
  logic [LINE_W-1:0]  hit_line;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-index invalid way wins; otherwise the oldest way of the set.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!way_valid[w] && !found) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_row[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  assign hit_line    = way_line[hit_way];
  assign cpu_data_o  = hit ? hit_line[word_sel*DATA_W +: DATA_W] : '0;
  assign cpu_stall_o = (state_q != IDLE) | (req & ~hit);

  always_comb begin
    way_fill = '0;
    way_wr   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      way_fill[w] = (state_q == REFILL) && mem_ack_i && (victim_q == WAY_W'(w));
      way_wr[w]   = (state_q == IDLE) && cpu_MemWrite_i && hit && (hit_way == WAY_W'(w));
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way_array #(
      .SETS   (SETS),
      .INDEX_W(INDEX_W),
      .TAG_W  (TAG_W),
      .LINE_W (LINE_W),
      .DATA_W (DATA_W),
      .WS_W   (WS_W)
    ) u_way (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rd_idx_i   (req_idx),
      .valid_o    (way_valid[g]),
      .dirty_o    (way_dirty[g]),
      .tag_o      (way_tag[g]),
      .line_o     (way_line[g]),
      .fill_i     (way_fill[g]),
      .fill_idx_i (req_idx_q),
      .fill_tag_i (req_tag_q),
      .fill_line_i(mem_data_i),
      .wr_i       (way_wr[g]),
      .wr_sel_i   (word_sel),
      .wr_data_i  (cpu_data_i)
    );
  end

  if (WAYS > 1) begin : g_lru
    logic [WAY_W-1:0]   age_q [SETS][WAYS];
    logic               touch;
    logic [WAY_W-1:0]   touch_way;
    logic [INDEX_W-1:0] touch_idx;

    // A refill touches the captured victim even if the request has since dropped.
    assign touch     = ((state_q == IDLE) && req && hit) || ((state_q == REFILL) && mem_ack_i);
    assign touch_way = (state_q == REFILL) ? victim_q : hit_way;
    assign touch_idx = (state_q == REFILL) ? req_idx_q : req_idx;

    always_comb begin
      for (int unsigned w = 0; w < WAYS; w++) age_row[w] = age_q[req_idx][w];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned s = 0; s < SETS; s++)
          for (int unsigned w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end else if (touch) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way)
            age_q[touch_idx][w] <= '0;
          else if (age_q[touch_idx][w] < age_q[touch_idx][touch_way])
            age_q[touch_idx][w] <= age_q[touch_idx][w] + 1'b1;
        end
      end
    end
  end else begin : g_dm
    assign age_row[0] = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      victim_q     <= '0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            victim_q     <= victim;
            req_tag_q    <= req_tag;
            req_idx_q    <= req_idx;
            mem_enable_q <= 1'b1;
            if (way_valid[victim] && way_dirty[victim]) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= ADDR_W'(line_addr(64'(way_tag[victim]), 64'(req_idx),
                                               INDEX_W, OFFSET_W));
              mem_data_q  <= way_line[victim];
            end else begin
              state_q     <= REFILL;
              mem_write_q <= 1'b0;
              mem_addr_q  <= ADDR_W'(line_addr(64'(req_tag), 64'(req_idx), INDEX_W, OFFSET_W));
            end
          end
        end
        // The refill request follows the write-back ack directly, without an idle bubble.
        WRITEBACK: begin
          if (mem_ack_i) begin
            state_q     <= REFILL;
            mem_write_q <= 1'b0;
            mem_addr_q  <= ADDR_W'(line_addr(64'(req_tag_q), 64'(req_idx_q), INDEX_W, OFFSET_W));
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            state_q      <= FILL;
            mem_enable_q <= 1'b0;
          end
        end
        FILL:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_nway_controller.sv
// Directed bench for dcache_nway_controller: 2-way instance driven from a vector table, 4-way for LRU order.
module tb_dcache_nway_controller;

  logic         clk, rst, sel;
  logic         rd, wr;
  logic [31:0]  addr, wdata;
  logic [255:0] mdata;
  logic         ack;

  logic [31:0]  data0, data4, maddr0, maddr4;
  logic [255:0] mdo0, mdo4;
  logic         stall0, stall4, men0, men4, mwe0, mwe4;

  logic         ack0, ack4;
  logic [31:0]  d_data, d_maddr;
  logic [255:0] d_mdo;
  logic         d_stall, d_en, d_we;

  assign ack0    = ack & ~sel;
  assign ack4    = ack & sel;
  assign d_data  = sel ? data4  : data0;
  assign d_stall = sel ? stall4 : stall0;
  assign d_maddr = sel ? maddr4 : maddr0;
  assign d_mdo   = sel ? mdo4   : mdo0;
  assign d_en    = sel ? men4   : men0;
  assign d_we    = sel ? mwe4   : mwe0;

  dcache_nway_controller #(.ADDR_W(32), .DATA_W(32), .LINE_BYTES(32), .SETS(16), .WAYS(2)) u0 (
    .clk_i(clk), .rst_i(rst), .cpu_MemRead_i(rd), .cpu_MemWrite_i(wr), .cpu_addr_i(addr),
    .cpu_data_i(wdata), .cpu_data_o(data0), .cpu_stall_o(stall0), .mem_data_i(mdata),
    .mem_ack_i(ack0), .mem_data_o(mdo0), .mem_addr_o(maddr0), .mem_enable_o(men0),
    .mem_write_o(mwe0));

  dcache_nway_controller #(.ADDR_W(32), .DATA_W(32), .LINE_BYTES(32), .SETS(16), .WAYS(4)) u4 (
    .clk_i(clk), .rst_i(rst), .cpu_MemRead_i(rd), .cpu_MemWrite_i(wr), .cpu_addr_i(addr),
    .cpu_data_i(wdata), .cpu_data_o(data4), .cpu_stall_o(stall4), .mem_data_i(mdata),
    .mem_ack_i(ack4), .mem_data_o(mdo4), .mem_addr_o(maddr4), .mem_enable_o(men4),
    .mem_write_o(mwe4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks = 0, failures = 0;
  int unsigned lat_wb = 3, lat_rf = 10;
  int unsigned stab_err = 0, en_err = 0;
  logic         wb_seen;
  logic [31:0]  wb_addr;
  logic [255:0] wb_line;
  logic [255:0] mem [int unsigned];

  function automatic logic [255:0] read_line(logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'h5000_0000 | (a + 32'(w * 4));
    return l;
  endfunction

  // Line memory: ack after a per-phase latency, and watch request stability and the post-ack drop.
  initial begin
    int unsigned cnt, lat;
    logic        prev_ack, prev_en, prev_wr;
    logic [31:0] prev_addr;
    logic [255:0] prev_data;
    ack = 1'b0; mdata = '0; cnt = 0; prev_ack = 0; prev_en = 0; prev_wr = 0;
    prev_addr = '0; prev_data = '0;
    forever begin
      @(posedge clk); #1;
      if (prev_ack) begin
        if (prev_wr) begin
          if (!(d_en && !d_we)) en_err++;
        end else if (d_en) en_err++;
      end
      if (d_en) begin
        if (prev_ack || !prev_en || (d_we != prev_wr)) cnt = 1;
        else begin
          cnt++;
          if ((d_maddr != prev_addr) || (d_we && (d_mdo != prev_data))) stab_err++;
        end
        lat = d_we ? lat_wb : lat_rf;
        if (cnt == lat) begin
          ack = 1'b1;
          if (d_we) begin
            mem[d_maddr] = d_mdo;
            wb_seen = 1'b1; wb_addr = d_maddr; wb_line = d_mdo;
          end else mdata = read_line(d_maddr);
        end else ack = 1'b0;
      end else begin
        ack = 1'b0; cnt = 0;
      end
      prev_ack = ack; prev_en = d_en; prev_wr = d_we; prev_addr = d_maddr; prev_data = d_mdo;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        output int unsigned stalls, output logic [31:0] dout, output logic tmo);
    wb_seen = 1'b0;
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; wdata = wd;
    stalls = 0; tmo = 1'b1; dout = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!d_stall) begin
        dout = d_data; tmo = 1'b0;
        break;
      end
      stalls++;
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    int unsigned lw, lr, stalls;
    logic        chk_data;
    logic [31:0] data;
    logic        wb;
    logic [31:0] wb_addr;
    int unsigned wb_off;
    logic [31:0] wb_word;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, logic [31:0] a, logic [31:0] wd, int unsigned lw,
                              int unsigned lr, int unsigned st, logic cd, logic [31:0] d, logic wb,
                              logic [31:0] wa, int unsigned wo, logic [31:0] ww);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = wd; v.lw = lw; v.lr = lr; v.stalls = st;
    v.chk_data = cd; v.data = d; v.wb = wb; v.wb_addr = wa; v.wb_off = wo; v.wb_word = ww;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    int unsigned st;
    logic [31:0]  dout;
    logic         tmo;
    logic [255:0] l;
    logic [31:0]  a4 [11];
    int unsigned  s4 [11];

    tbl[0]  = mk(1, 0, 32'h100, 0, 3, 10, 12, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 32'h104, 0, 3, 10, 0, 1, 32'h5000_0104, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 32'h108, 32'hCAFEF00D, 3, 10, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 32'h108, 0, 3, 10, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 32'h000, 0, 3, 10, 12, 1, 32'h5000_0000, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 32'h200, 0, 3, 10, 12, 1, 32'h5000_0200, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 32'h000, 32'h11223344, 3, 10, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 32'h400, 0, 3, 10, 12, 1, 32'h5000_0400, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 32'h200, 0, 3, 10, 15, 1, 32'h5000_0200, 1, 32'h000, 0, 32'h11223344);
    tbl[9]  = mk(1, 0, 32'h000, 0, 3, 10, 12, 1, 32'h11223344, 0, 0, 0, 0);
    tbl[10] = mk(1, 1, 32'h104, 32'h77777777, 3, 10, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 32'h300, 0, 3, 10, 12, 1, 32'h5000_0300, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 32'h500, 0, 1, 20, 23, 1, 32'h5000_0500, 1, 32'h100, 8, 32'hCAFEF00D);
    tbl[13] = mk(0, 1, 32'h300, 32'h33333333, 3, 10, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 32'h500, 0, 3, 10, 0, 1, 32'h5000_0500, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 32'h100, 0, 20, 1, 23, 1, 32'hDEADBEEF, 1, 32'h300, 0, 32'h33333333);
    tbl[16] = mk(1, 0, 32'h104, 0, 3, 10, 0, 1, 32'h77777777, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 32'h604, 32'h60460400, 3, 10, 12, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 32'h604, 0, 3, 10, 0, 1, 32'h60460400, 0, 0, 0, 0);
    tbl[19] = mk(1, 0, 32'h600, 0, 3, 10, 0, 1, 32'h5000_0600, 0, 0, 0, 0);

    l = read_line(32'h100);
    l[31:0] = 32'hDEADBEEF;
    mem[32'h100] = l;

    sel = 1'b0; rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; wb_seen = 1'b0;
    wb_addr = '0; wb_line = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_stall", 64'(d_stall), 0);
    check("rst_mem_en", 64'(d_en), 0);
    check("rst_mem_we", 64'(d_we), 0);
    check("rst_mem_addr", 64'(d_maddr), 0);
    check("rst_mem_data", 64'(d_mdo[63:0]), 0);
    check("rst_cpu_data", 64'(d_data), 0);

    for (int i = 0; i < 20; i++) begin
      lat_wb = tbl[i].lw; lat_rf = tbl[i].lr;
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, st, dout, tmo);
      check($sformatf("r%0d_timeout", i), 64'(tmo), 0);
      check($sformatf("r%0d_stalls", i), 64'(st), 64'(tbl[i].stalls));
      if (tbl[i].chk_data) check($sformatf("r%0d_data", i), 64'(dout), 64'(tbl[i].data));
      check($sformatf("r%0d_wb_seen", i), 64'(wb_seen), 64'(tbl[i].wb));
      if (tbl[i].wb) begin
        check($sformatf("r%0d_wb_addr", i), 64'(wb_addr), 64'(tbl[i].wb_addr));
        check($sformatf("r%0d_wb_word", i), 64'(wb_line[tbl[i].wb_off*8 +: 32]),
              64'(tbl[i].wb_word));
      end
    end

    // Reset in the middle of a refill, then the same set must miss again.
    lat_wb = 3; lat_rf = 10;
    @(posedge clk); #1;
    rd = 1'b1; addr = 32'h700;
    repeat (4) @(negedge clk);
    check("mid_stall", 64'(d_stall), 1);
    check("mid_mem_en", 64'(d_en), 1);
    check("mid_mem_we", 64'(d_we), 0);
    check("mid_mem_addr", 64'(d_maddr), 64'h700);
    #2;
    rst = 1'b1; rd = 1'b0;
    #1;
    check("rstmid_mem_en", 64'(d_en), 0);
    check("rstmid_stall", 64'(d_stall), 0);
    check("rstmid_mem_addr", 64'(d_maddr), 0);
    check("rstmid_cpu_data", 64'(d_data), 0);
    @(negedge clk); rst = 1'b0;
    access(1'b1, 1'b0, 32'h100, 0, st, dout, tmo);
    check("post_rst_stalls", 64'(st), 12);
    check("post_rst_data", 64'(dout), 64'hDEADBEEF);

    // 4-way LRU order: fill set 0, re-touch ways 0 and 1, miss evicts way 2 (0x400).
    @(negedge clk); sel = 1'b1; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    a4 = '{32'h000, 32'h200, 32'h400, 32'h600, 32'h000, 32'h200, 32'h800,
           32'h000, 32'h200, 32'h600, 32'h400};
    s4 = '{12, 12, 12, 12, 0, 0, 12, 0, 0, 0, 12};
    for (int i = 0; i < 11; i++) begin
      access(1'b1, 1'b0, a4[i], 0, st, dout, tmo);
      check($sformatf("w4_%0d_stalls", i), 64'(st), 64'(s4[i]));
      check($sformatf("w4_%0d_wb_seen", i), 64'(wb_seen), 0);
    end

    check("mem_req_stable", 64'(stab_err), 0);
    check("mem_en_after_ack", 64'(en_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
